// File: rtl/alu_pipe_fwd.sv
// Four-stage ALU pipeline (operand read, execute, writeback, memory store)
// with RD/EX forwarding, global hold, immediate operands and debug read ports.
module alu_pipe_fwd #(
  parameter int N   = 16,
  parameter int M   = 3,
  parameter int ADR = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  input  logic           hold,
  input  logic [M-1:0]   rs1,
  input  logic [M-1:0]   rs2,
  input  logic [M-1:0]   rd,
  input  logic [2:0]     f,
  input  logic           use_imm,
  input  logic [N-1:0]   imm,
  input  logic [ADR-1:0] addr,
  output logic [N-1:0]   z,
  output logic           z_valid,
  output logic           zero,
  output logic           carry,
  input  logic [M-1:0]   rf_sel,
  output logic [N-1:0]   rf_data,
  input  logic [ADR-1:0] mem_raddr,
  output logic [N-1:0]   mem_rdata
);

  localparam int NREG = 1 << M;
  localparam int NMEM = 1 << ADR;

  logic [N-1:0]   rf  [NREG];
  logic [N-1:0]   mem [NMEM];

  logic [N-1:0]   s1_a;
  logic [N-1:0]   s1_b;
  logic [2:0]     s1_f;
  logic [M-1:0]   s1_rd;
  logic [ADR-1:0] s1_addr;
  logic           s1_valid;

  logic [N-1:0]   s2_z;
  logic           s2_carry;
  logic [M-1:0]   s2_rd;
  logic [ADR-1:0] s2_addr;
  logic           s2_valid;

  logic [ADR-1:0] s3_addr;

  logic [N-1:0]   alu_z;
  logic           alu_c;
  logic [N:0]     sum_ext;
  logic [N-1:0]   fwd_a;
  logic [N-1:0]   fwd_b;

  // ALU on the operands held in the RD stage
  always_comb begin
    alu_z   = {N{1'b0}};
    alu_c   = 1'b0;
    sum_ext = {1'b0, s1_a} + {1'b0, s1_b};
    case (s1_f)
      3'b000: begin
        alu_z = sum_ext[N-1:0];
        alu_c = sum_ext[N];
      end
      3'b001: begin
        alu_z = s1_a - s1_b;
        alu_c = (s1_a < s1_b);
      end
      3'b010: alu_z = s1_a * s1_b;
      3'b011: alu_z = s1_a & s1_b;
      3'b100: alu_z = s1_a | s1_b;
      3'b101: alu_z = s1_a ^ s1_b;
      3'b110: alu_z = ~s1_a;
      3'b111: alu_z = ~s1_b;
      default: begin
        alu_z = {N{1'b0}};
        alu_c = 1'b0;
      end
    endcase
  end

  // Operand a: youngest matching producer wins (RD-stage ALU, then EX, then regfile)
  always_comb begin
    fwd_a = rf[rs1];
    if (s1_valid && (s1_rd == rs1)) begin
      fwd_a = alu_z;
    end else if (s2_valid && (s2_rd == rs1)) begin
      fwd_a = s2_z;
    end else begin
      fwd_a = rf[rs1];
    end
  end

  // Operand b: immediate bypasses forwarding entirely
  always_comb begin
    fwd_b = rf[rs2];
    if (use_imm) begin
      fwd_b = imm;
    end else if (s1_valid && (s1_rd == rs2)) begin
      fwd_b = alu_z;
    end else if (s2_valid && (s2_rd == rs2)) begin
      fwd_b = s2_z;
    end else begin
      fwd_b = rf[rs2];
    end
  end

  // Pipeline stage registers RD -> EX -> WB; hold freezes every stage
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_a     <= {N{1'b0}};
      s1_b     <= {N{1'b0}};
      s1_f     <= 3'b000;
      s1_rd    <= {M{1'b0}};
      s1_addr  <= {ADR{1'b0}};
      s1_valid <= 1'b0;
      s2_z     <= {N{1'b0}};
      s2_carry <= 1'b0;
      s2_rd    <= {M{1'b0}};
      s2_addr  <= {ADR{1'b0}};
      s2_valid <= 1'b0;
      s3_addr  <= {ADR{1'b0}};
      z        <= {N{1'b0}};
      z_valid  <= 1'b0;
      zero     <= 1'b0;
      carry    <= 1'b0;
    end else if (!hold) begin
      // Bubbles carry all-zero payload so they compute 0 with no carry
      if (in_valid) begin
        s1_a    <= fwd_a;
        s1_b    <= fwd_b;
        s1_f    <= f;
        s1_rd   <= rd;
        s1_addr <= addr;
      end else begin
        s1_a    <= {N{1'b0}};
        s1_b    <= {N{1'b0}};
        s1_f    <= 3'b000;
        s1_rd   <= {M{1'b0}};
        s1_addr <= {ADR{1'b0}};
      end
      s1_valid <= in_valid;

      s2_z     <= alu_z;
      s2_carry <= alu_c & s1_valid;
      s2_rd    <= s1_rd;
      s2_addr  <= s1_addr;
      s2_valid <= s1_valid;

      z        <= s2_z;
      z_valid  <= s2_valid;
      zero     <= s2_valid & (s2_z == {N{1'b0}});
      carry    <= s2_carry & s2_valid;
      s3_addr  <= s2_addr;
    end
  end

  // Register file: cleared by reset, written from the EX stage at writeback
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) begin
        rf[i] <= {N{1'b0}};
      end
    end else if (!hold && s2_valid) begin
      rf[s2_rd] <= s2_z;
    end
  end

  // Data memory store from the WB stage; contents survive reset
  always_ff @(posedge clk) begin
    if (!rst && !hold && z_valid) begin
      mem[s3_addr] <= z;
    end
  end

  assign rf_data   = rf[rf_sel];
  assign mem_rdata = mem[mem_raddr];

endmodule

// File: doc/alu_pipe_fwd.md
# alu_pipe_fwd

Four-stage, single-clock, parametrised ALU pipeline: operand read → execute → register writeback → memory store. It generalises the team's two-phase pipelined ALU in several ways. Data width, register count and memory depth are parameters. Per-instruction valid tracking and a global hold are added. An immediate operand mode is added. A forwarding network removes read-after-write hazards between back-to-back instructions. The block sits as the datapath core under the sequencer; results go both to the internal register file and to a word-addressed data memory.

## Interface
- N, 16, data width (bits)
- M, 3, register-select width; register file has 2**M entries
- ADR, 8, memory address width; memory has 2**ADR words of N bits
- clk  input  1  single clock, all state updates on rising edge
- rst  input  1  asynchronous, active-high reset
- in_valid  input  1  instruction present on rs1/rs2/rd/f/addr/imm/use_imm
- hold  input  1  freeze entire pipeline this cycle
- rs1, rs2, rd  input  M  source/destination register selects
- f  input  3  function: 000 add, 001 sub, 010 mul (low N bits), 011 and, 100 or, 101 xor, 110 ~a, 111 ~b
- use_imm  input  1  operand b = imm instead of reg[rs2]
- imm  input  N  immediate operand
- addr  input  ADR  memory store address for this instruction
- z  output  N  writeback-stage result
- z_valid  output  1  z holds a valid instruction result
- zero  output  1  z == 0 (qualified by z_valid)
- carry  output  1  add carry-out / sub borrow; 0 for other functions
- rf_sel  input  M  debug register read select
- rf_data  output  N  combinational reg[rf_sel]
- mem_raddr  input  ADR  debug memory read address
- mem_rdata  output  N  combinational mem[mem_raddr]

## Operation
- Stage RD (edge k, in_valid=1, hold=0): capture operands a, b, rd, f, addr, valid=1. in_valid=0 captures a bubble (valid=0).
- Stage EX (edge k+1): ALU result, carry, rd, addr and valid pass into EX registers.
- Stage WB (edge k+2): reg[ex_rd] ← ex_z if ex_valid; z/z_valid/zero/carry update.
- Stage MEM (edge k+3): mem[wb_addr] ← z if z_valid.
- Bubbles write nothing, to either the register file or the memory.
- Forwarding for a and for b (b only when use_imm=0), priority high→low:
  - live ALU output of RD-stage instruction, if valid and rd matches;
  - EX-stage result, if valid and rd matches;
  - register file.
- Register 0 is an ordinary writable register.
- Arithmetic is modulo 2**N. mul keeps the low N bits. sub carry = 1 when a < b, unsigned.
- hold=1 behaviour:
  - No stage register changes and no register-file or memory write occurs.
  - in_valid is ignored and the instruction is not accepted; the source must re-present it.
  - Outputs stay constant.
- rst=1, immediate regardless of clk:
  - all valids = 0; all stage registers = 0; all register-file entries = 0;
  - z = 0, z_valid = 0, zero = 0, carry = 0.
  - Memory contents are not reset.
- Reset mid-stream discards every in-flight instruction. No partial writes occur after rst asserts.

## Timing
- Latency: instruction accepted at edge k → z/z_valid at edge k+2, register file updated at edge k+2, memory updated at edge k+3.
- Throughput: one instruction per cycle with no hazard stalls.
- Dependent instruction issued the very next cycle sees the correct value via forwarding.
- An instruction issued two cycles after its producer reads the EX forward path.
- An instruction issued three or more cycles after its producer reads the register file.
- hold cycles add one cycle of latency each to every in-flight instruction.
- rf_data and mem_rdata reflect writes performed at the preceding edge.
- No register-file write-then-read same-edge bypass is needed beyond the forwarding rules above.

## Test plan
- Reset: issue 3 instructions, assert rst between edges → z=0, z_valid=0, zero=0, carry=0 immediately; rf_data=0 for all 8 sel values; no memory change at the following edge.
- Back-to-back forwarding:
  - Stimulus: r1=r0+imm 5, r2=r0+imm 3, r3=r1+r2 on consecutive cycles.
  - Response: z sequence 5, 3, 8; rf_data[r3]=8.
- Subtract borrow: after the forwarding test, r4=r2−r1 → z=16'hFFFE, carry=1, zero=0.
- Subtract zero: r5=r1−r1 → z=0, zero=1, carry=0.
- Multiply wrap: r1=r0+imm 300, then r6=r1*r1 next cycle → z=24464 (90000 mod 65536).
- Hold and memory store:
  - Stimulus: stream r1=r0+imm 8 with addr=12, with hold=1 for two cycles after acceptance.
  - Response: z_valid arrives 2 cycles late; the result 8 is written exactly once; mem_rdata at address 12 reads 8 one edge after z_valid.
  - Issuing with in_valid=0 produces no register or memory writes.
